decode_queue: RTL



---
 rtl/decode_queue_if.sv | 82 ++++++++
 rtl/decode_queue.sv | 110 +++++++++++
 2 files changed

// File: rtl/decode_queue_if.sv
// Decoded-instruction bundle types and the decoder/dispatch-facing
// interface of the decode queue.

package decode_queue_pkg;

  typedef struct packed {
    logic       valid;
    logic [4:0] addr;
  } RegFile_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } ImmData_t;

  typedef enum logic [1:0] {
    UNIT_NOP = 2'd0,
    UNIT_ALU = 2'd1,
    UNIT_LSU = 2'd2,
    UNIT_BRU = 2'd3
  } ExeUnit_t;

  typedef logic [3:0] OpCommand_t;

  // One queue entry: everything the decoder hands over for a single instruction.
  typedef struct packed {
    RegFile_t   rs1;
    RegFile_t   rs2;
    RegFile_t   rd;
    logic       invalid;
    ImmData_t   imm_data;
    ExeUnit_t   unit;
    OpCommand_t command;
  } entry_t;

endpackage

interface decode_queue_if #(
  parameter int DEPTH = 8,
  parameter int CNTW  = $clog2(DEPTH) + 1
);
  import decode_queue_pkg::*;

  // Decoder side
  logic       flush;
  logic       dec_e_;
  RegFile_t   rs1;
  RegFile_t   rs2;
  RegFile_t   rd;
  logic       invalid;
  ImmData_t   imm_data;
  ExeUnit_t   unit;
  OpCommand_t command;
  logic       is_full;

  // Dispatch side
  logic       issue_e_;
  logic       issue_ready;
  RegFile_t   issue_rs1;
  RegFile_t   issue_rs2;
  RegFile_t   issue_rd;
  logic       issue_invalid;
  ImmData_t   issue_imm_data;
  ExeUnit_t   issue_unit;
  OpCommand_t issue_command;
  logic [CNTW-1:0] count;

  // Producer/consumer view (decoder, dispatch, testbench)
  modport master (
    output flush, dec_e_, rs1, rs2, rd, invalid, imm_data, unit, command, issue_ready,
    input  is_full, issue_e_, issue_rs1, issue_rs2, issue_rd, issue_invalid,
           issue_imm_data, issue_unit, issue_command, count
  );

  // Queue view
  modport slave (
    input  flush, dec_e_, rs1, rs2, rd, invalid, imm_data, unit, command, issue_ready,
    output is_full, issue_e_, issue_rs1, issue_rs2, issue_rd, issue_invalid,
           issue_imm_data, issue_unit, issue_command, count
  );

endinterface

// File: rtl/decode_queue.sv
// Decoded-instruction FIFO between the decoder and dispatch. Back-pressure
// (is_full) and the head view are derived only from registered state, so
// there is no combinational path from dec_e_/issue_ready to is_full.

module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNTW  = $clog2(DEPTH) + 1
) (
  input logic          clk,
  input logic          reset_,
  decode_queue_if.slave dq_if
);

  localparam int PW = $clog2(DEPTH);

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wp_q, wp_d;
  logic [PW-1:0]   rp_q, rp_d;
  logic [CNTW-1:0] count_q, count_d;

  logic   empty_s;
  logic   full_s;
  logic   push_s;
  logic   pop_s;
  entry_t wr_ent_s;
  entry_t head_s;

  assign empty_s = (count_q == CNTW'(0));
  assign full_s  = (count_q == CNTW'(DEPTH));

  // Flush wins over both push and pop; full blocks push even if a pop happens now.
  assign push_s = ~dq_if.dec_e_ & ~full_s & ~dq_if.flush;
  assign pop_s  = ~empty_s & dq_if.issue_ready & ~dq_if.flush;

  assign wr_ent_s.rs1      = dq_if.rs1;
  assign wr_ent_s.rs2      = dq_if.rs2;
  assign wr_ent_s.rd       = dq_if.rd;
  assign wr_ent_s.invalid  = dq_if.invalid;
  assign wr_ent_s.imm_data = dq_if.imm_data;
  assign wr_ent_s.unit     = dq_if.unit;
  assign wr_ent_s.command  = dq_if.command;

  // Next-state for pointers and occupancy.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (dq_if.flush) begin
      wp_d    = PW'(0);
      rp_d    = PW'(0);
      count_d = CNTW'(0);
    end else begin
      if (push_s) begin
        wp_d = wp_q + PW'(1);
      end else begin
        wp_d = wp_q;
      end
      if (pop_s) begin
        rp_d = rp_q + PW'(1);
      end else begin
        rp_d = rp_q;
      end
      count_d = count_q + CNTW'(push_s) - CNTW'(pop_s);
    end
  end

  // Pointer and occupancy registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wp_q    <= PW'(0);
      rp_q    <= PW'(0);
      count_q <= CNTW'(0);
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Entry storage; deliberately not reset, occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wp_q] <= wr_ent_s;
    end
  end

  // Head view: zeros while empty so dispatch never sees stale fields.
  always_comb begin
    head_s = '0;
    if (empty_s) begin
      head_s = '0;
    end else begin
      head_s = mem_q[rp_q];
    end
  end

  assign dq_if.is_full        = full_s;
  assign dq_if.issue_e_       = empty_s;
  assign dq_if.count          = count_q;
  assign dq_if.issue_rs1      = head_s.rs1;
  assign dq_if.issue_rs2      = head_s.rs2;
  assign dq_if.issue_rd       = head_s.rd;
  assign dq_if.issue_invalid  = head_s.invalid;
  assign dq_if.issue_imm_data = head_s.imm_data;
  assign dq_if.issue_unit     = head_s.unit;
  assign dq_if.issue_command  = head_s.command;

endmodule
